// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests, buffers responses for decode.
// Latency: imem_req one cycle after reset release; if_valid two cycles after grant with a 1-cycle memory.
// Backpressure: stall holds the output entry; requests stop once in-flight + buffered + dropped reach DEPTH.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PCs produce one if_adel entry instead of a fetch.
module fetch_pc_unit #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter int               DEPTH      = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             if_adel
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic             run_q;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]    out_q, out_d;     // live requests whose responses will be kept
    logic [CW-1:0]    drop_q, drop_d;   // in-flight responses belonging to a flushed stream
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [AW-1:0]    aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;

    logic [WIDTH-1:0] aq_mem   [DEPTH];
    logic [WIDTH-1:0] fifo_pc  [DEPTH];
    logic [WIDTH-1:0] fifo_dat [DEPTH];

    logic             flush, pop, push, fire, have_credit, pc_ok, adel_push;
    logic             rsp, rsp_drop, rsp_live;
    logic [WIDTH-1:0] target, push_pc, push_dat;
    logic [SW-1:0]    occupancy;

    assign flush  = exc_req | eret_req | redirect_valid;
    assign target = exc_req  ? EXC_VECTOR :
                    eret_req ? epc        : redirect_pc;

    assign if_valid = (cnt_q != '0);
    assign pop      = if_valid & ~stall & ~flush;

    // A slot freed by this cycle's pop is reusable at once, which keeps a
    // 1-cycle memory streaming at one instruction per cycle with DEPTH=2.
    assign occupancy   = SW'(out_q) + SW'(cnt_q) + SW'(drop_q) - SW'(pop);
    assign have_credit = (occupancy < SW'(DEPTH));

`ifdef FETCH_ALIGN_CHECK_EN
    logic adel_done_q;
    logic fifo_adel [DEPTH];
    assign pc_ok     = (pc_q[1:0] == 2'b00);
    assign adel_push = run_q & ~flush & ~pc_ok & ~adel_done_q & have_credit;
    assign imem_addr = pc_q;
    assign if_adel   = if_valid ? fifo_adel[fifo_rd_q] : 1'b0;

    // One address-error entry per misaligned PC; re-armed by the next flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         adel_done_q <= 1'b0;
        else if (flush)     adel_done_q <= 1'b0;
        else if (adel_push) adel_done_q <= 1'b1;
    end

    // Address-error flag travels alongside its FIFO entry.
    always_ff @(posedge clk) begin
        if (push) fifo_adel[fifo_wr_q] <= adel_push;
    end
`else
    assign pc_ok     = 1'b1;
    assign adel_push = 1'b0;
    assign imem_addr = {pc_q[WIDTH-1:2], 2'b00};
    assign if_adel   = 1'b0;
`endif

    assign imem_req = run_q & ~flush & have_credit & pc_ok;
    assign fire     = imem_req & imem_gnt;

    // Responses beyond what is in flight are protocol errors and are ignored.
    // Dropped responses are always older than live ones, so they are consumed first.
    assign rsp      = imem_rvalid & ((out_q != '0) | (drop_q != '0));
    assign rsp_drop = rsp & (drop_q != '0);
    assign rsp_live = rsp & (drop_q == '0);

    assign push     = (rsp_live & ~flush) | adel_push;
    assign push_pc  = rsp_live ? aq_mem[aq_rd_q] : pc_q;
    assign push_dat = rsp_live ? imem_rdata : '0;

    assign if_pc    = if_valid ? fifo_pc[fifo_rd_q]  : '0;
    assign if_instr = if_valid ? fifo_dat[fifo_rd_q] : '0;

    // Next-state: counters, pointers and PC; a flush overrides everything and
    // turns all live in-flight requests into responses to be dropped.
    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q;
        drop_d    = drop_q;
        fifo_rd_d = fifo_rd_q;
        fifo_wr_d = fifo_wr_q;
        aq_rd_d   = aq_rd_q;
        aq_wr_d   = aq_wr_q;
        if (rsp_drop) drop_d = drop_q - CW'(1);
        if (rsp_live) begin
            out_d   = out_q - CW'(1);
            aq_rd_d = aq_rd_q + AW'(1);
        end
        if (fire) begin
            out_d   = out_d + CW'(1);
            aq_wr_d = aq_wr_q + AW'(1);
            pc_d    = pc_q + PC_STEP;
        end
        if (push) fifo_wr_d = fifo_wr_q + AW'(1);
        if (pop)  fifo_rd_d = fifo_rd_q + AW'(1);
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            pc_d      = target;
            drop_d    = drop_d + out_d;
            out_d     = '0;
            cnt_d     = '0;
            fifo_rd_d = '0;
            fifo_wr_d = '0;
            aq_rd_d   = '0;
            aq_wr_d   = '0;
        end
    end

    // Control state; run_q keeps imem_req low for the cycle of reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            out_q     <= '0;
            drop_q    <= '0;
            cnt_q     <= '0;
            fifo_rd_q <= '0;
            fifo_wr_q <= '0;
            aq_rd_q   <= '0;
            aq_wr_q   <= '0;
        end else begin
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            cnt_q     <= cnt_d;
            fifo_rd_q <= fifo_rd_d;
            fifo_wr_q <= fifo_wr_d;
            aq_rd_q   <= aq_rd_d;
            aq_wr_q   <= aq_wr_d;
        end
    end

    // Storage arrays need no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fire) aq_mem[aq_wr_q] <= pc_q;
        if (push) begin
            fifo_pc[fifo_wr_q]  <= push_pc;
            fifo_dat[fifo_wr_q] <= push_dat;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: cycle table for start-up/stall/flush, directed corner sequences,
// then randomized traffic checked against an address-stream reference model.
// Memory model returns responses in order, one or more cycles after grant.
module tb_fetch_pc_unit;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] VEC    = 32'h0000_4180;

    logic        clk = 1'b0, reset = 1'b0, stall = 1'b0;
    logic        redirect_valid = 1'b0, exc_req = 1'b0, eret_req = 1'b0, imem_gnt = 1'b0;
    logic [31:0] redirect_pc = '0, epc = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req, if_valid, if_adel;
    logic [31:0] imem_addr, if_pc, if_instr;

    int tests = 0, fails = 0;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_adel(if_adel)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(logic [31:0] a);
        return a ^ 32'hDEAD_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // ---------------- memory model ----------------
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];
    int    cyc = 0, last_due = 0, mem_lat = 1;
    bit    mem_rand = 1'b0;

    always @(posedge clk) begin
        int due;
        if (!reset) begin
            mq.delete();
            last_due = 0;
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end else begin
            if (imem_req && imem_gnt) begin
                due = cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{imem_addr, due});
            end
        end
        cyc++;
        if (reset && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= memf(mq[0].addr);
            void'(mq.pop_front());
        end else if (reset) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; redirect_valid = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
        redirect_pc = '0; epc = '0; imem_gnt = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic expect_grant(string nm, logic [31:0] exp);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                chk(nm, imem_addr, exp);
                seen = 1'b1;
            end
            next_cycle();
        end
        if (!seen) timeout_fail(nm);
    endtask

    task automatic expect_out(string nm, logic [31:0] pc_e, logic [31:0] ins_e, logic adel_e);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (if_valid) begin
                chk({nm, " pc"}, if_pc, pc_e);
                chk({nm, " instr"}, if_instr, ins_e);
                chk({nm, " adel"}, 32'(if_adel), 32'(adel_e));
                seen = 1'b1;
            end
            next_cycle();
        end
        if (!seen) timeout_fail(nm);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic stall; logic rdr; logic [31:0] rdr_pc; logic exc; logic eret; logic [31:0] epc_v;
        logic req; logic [31:0] addr; logic vld; logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(logic s, logic r, logic [31:0] rp, logic e, logic er,
                                logic [31:0] ep, logic q, logic [31:0] a, logic v, logic [31:0] p);
        vec_t t;
        t.stall = s; t.rdr = r; t.rdr_pc = rp; t.exc = e; t.eret = er; t.epc_v = ep;
        t.req = q; t.addr = a; t.vld = v; t.pc = p;
        return t;
    endfunction

    vec_t tbl[20];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_f, exp_o, tgt;
        bit          prev_fl, fl;
        int          acc;

        // columns: stall rdr rdr_pc exc eret epc | req addr valid pc
        tbl[0]  = mk(0, 0, 0,            0, 0, 0,            0, 0,            0, 0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h3000,     0, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h3004,     0, 0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h3008,     1, 32'h3000);
        tbl[4]  = mk(1, 0, 0,            0, 0, 0,            0, 0,            1, 32'h3004);
        tbl[5]  = mk(1, 0, 0,            0, 0, 0,            0, 0,            1, 32'h3004);
        tbl[6]  = mk(1, 0, 0,            0, 0, 0,            0, 0,            1, 32'h3004);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h300C,     1, 32'h3004);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,            1, 32'h3010,     1, 32'h3008);
        tbl[9]  = mk(0, 1, 32'h3100,     0, 0, 0,            0, 0,            1, 32'h300C);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,            1, 32'h3100,     0, 0);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,            1, 32'h3104,     0, 0);
        tbl[12] = mk(0, 1, 32'h3200,     1, 0, 0,            0, 0,            1, 32'h3100);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,            1, 32'h4180,     0, 0);
        tbl[14] = mk(0, 0, 0,            0, 0, 0,            1, 32'h4184,     0, 0);
        tbl[15] = mk(0, 0, 0,            0, 1, 32'h3044,     0, 0,            1, 32'h4180);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,            1, 32'h3044,     0, 0);
        tbl[17] = mk(0, 0, 0,            0, 0, 0,            1, 32'h3048,     0, 0);
        tbl[18] = mk(0, 0, 0,            0, 0, 0,            1, 32'h304C,     1, 32'h3044);
        tbl[19] = mk(0, 0, 0,            0, 0, 0,            1, 32'h3050,     1, 32'h3048);

        // reset state
        clear_inputs();
        #2;
        chk("reset imem_req", 32'(imem_req), 0);
        chk("reset if_valid", 32'(if_valid), 0);
        chk("reset if_pc", if_pc, 0);
        chk("reset if_instr", if_instr, 0);
        chk("reset if_adel", 32'(if_adel), 0);
        repeat (3) next_cycle();
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            stall = tbl[i].stall; redirect_valid = tbl[i].rdr; redirect_pc = tbl[i].rdr_pc;
            exc_req = tbl[i].exc; eret_req = tbl[i].eret; epc = tbl[i].epc_v; imem_gnt = 1'b1;
            @(negedge clk);
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].pc);
                chk($sformatf("row%0d if_instr", i), if_instr, memf(tbl[i].pc));
                chk($sformatf("row%0d if_adel", i), 32'(if_adel), 0);
            end
            next_cycle();
        end
        clear_inputs();

        // redirect with two slow fetches in flight: both responses must be discarded
        do_reset();
        mem_lat = 3;
        repeat (3) next_cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        @(negedge clk);
        chk("slow redirect imem_req", 32'(imem_req), 0);
        chk("slow redirect if_valid", 32'(if_valid), 0);
        next_cycle();
        redirect_valid = 1'b0;
        expect_grant("slow redirect first fetch", 32'h3100);
        expect_out("slow redirect first out", 32'h3100, memf(32'h3100), 1'b0);
        expect_out("slow redirect second out", 32'h3104, memf(32'h3104), 1'b0);
        mem_lat = 1;

        // PC wraps from the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        expect_grant("wrap fetch top", 32'hFFFF_FFFC);
        expect_grant("wrap fetch zero", 32'h0000_0000);
        expect_out("wrap out top", 32'hFFFF_FFFC, memf(32'hFFFF_FFFC), 1'b0);
        expect_out("wrap out zero", 32'h0000_0000, memf(32'h0), 1'b0);

        // asynchronous reset in the middle of a cycle while streaming
        #1;
        chk("async pre if_valid", 32'(if_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("async imem_req", 32'(imem_req), 0);
        chk("async if_valid", 32'(if_valid), 0);
        chk("async if_pc", if_pc, 0);
        next_cycle();
        reset = 1'b1;
        expect_grant("after async reset fetch", RST_PC);
        expect_out("after async reset out", RST_PC, memf(RST_PC), 1'b0);

`ifdef FETCH_ALIGN_CHECK_EN
        begin
            bit seen = 1'b0;
            redirect_valid = 1'b1; redirect_pc = 32'h3102; stall = 1'b1;
            next_cycle();
            redirect_valid = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                chk("adel no fetch", 32'(imem_req), 0);
                if (if_valid) begin
                    chk("adel if_pc", if_pc, 32'h3102);
                    chk("adel if_instr", if_instr, 0);
                    chk("adel if_adel", 32'(if_adel), 1);
                    seen = 1'b1;
                end
                next_cycle();
            end
            if (!seen) timeout_fail("adel entry");
            @(negedge clk);
            chk("adel held if_pc", if_pc, 32'h3102);
            chk("adel held imem_req", 32'(imem_req), 0);
            next_cycle();
            stall = 1'b0;
            next_cycle();
            @(negedge clk);
            chk("adel single entry", 32'(if_valid), 0);
            chk("adel pc holds", 32'(imem_req), 0);
            next_cycle();
            exc_req = 1'b1;
            next_cycle();
            exc_req = 1'b0;
            expect_grant("adel exc fetch", VEC);
            expect_out("adel exc out", VEC, memf(VEC), 1'b0);
        end
`endif

        // randomized traffic against the address-stream model
        do_reset();
        mem_rand = 1'b1;
        exp_f = RST_PC; exp_o = RST_PC; prev_fl = 1'b0; acc = 0;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(0, 99) < 30);
            exc_req        = ($urandom_range(0, 59) == 0);
            eret_req       = ($urandom_range(0, 49) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = {16'h0, 4'h3, 10'($urandom_range(0, 1023)), 2'b00};
            epc            = {16'h0, 4'h3, 10'($urandom_range(0, 1023)), 2'b00};
            imem_gnt       = ($urandom_range(0, 99) < 75);
            @(negedge clk);
            fl = exc_req | eret_req | redirect_valid;
            if (prev_fl) chk("rnd if_valid after flush", 32'(if_valid), 0);
            if (fl) begin
                chk("rnd imem_req on flush", 32'(imem_req), 0);
                tgt   = exc_req ? VEC : (eret_req ? epc : redirect_pc);
                exp_f = tgt;
                exp_o = tgt;
            end else begin
                if (imem_req && imem_gnt) begin
                    chk("rnd imem_addr", imem_addr, exp_f);
                    exp_f = exp_f + 32'd4;
                end
                if (if_valid && !stall) begin
                    chk("rnd if_pc", if_pc, exp_o);
                    chk("rnd if_instr", if_instr, memf(exp_o));
                    chk("rnd if_adel", 32'(if_adel), 0);
                    exp_o = exp_o + 32'd4;
                    acc++;
                end
            end
            prev_fl = fl;
            next_cycle();
        end
        clear_inputs();
        tests++;
        if (acc < 200) begin
            fails++;
            $display("FAIL rnd throughput: %0d instructions delivered, need at least 200", acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the PC pipeline register and the IF/ID register.
- Owns the fetch PC and selects the next PC: sequential, branch/jump redirect, exception vector or ERET.
- Issues requests to instruction memory over a request/grant channel and buffers in-order responses in a small FIFO.
- Presents {pc, instr, valid} to the decode side; honours the hazard-unit stall.

Parameters:
WIDTH, 32, address/data width
RESET_PC, 32'h0000_3000, fetch PC after reset
EXC_VECTOR, 32'h0000_4180, exception handler entry
DEPTH, 2, response FIFO entries = max outstanding + buffered fetches (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  decode side not accepting; hold output entry
redirect_valid  in  1  branch/jump taken, resolved in D
redirect_pc  in  WIDTH  branch/jump target
exc_req  in  1  exception/interrupt taken
eret_req  in  1  ERET executing
epc  in  WIDTH  return address for ERET
imem_req  out  1  fetch request valid
imem_addr  out  WIDTH  fetch address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (in request order, >=1 cycle after grant)
imem_rdata  in  WIDTH  instruction word
if_valid  out  1  output entry valid
if_pc  out  WIDTH  PC of output instruction
if_instr  out  WIDTH  output instruction
if_adel  out  1  address-error-on-fetch flag (see Optional Feature)

Behaviour:
- Reset asserted (reset==0): pc=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req=0, if_valid=0, if_pc=0, if_instr=0, if_adel=0. Reset mid-transaction discards everything; late imem_rvalid after release is dropped only if counted in drop (outstanding cleared, so memory must be quiesced by the system).
- Next-PC priority per cycle: exc_req > eret_req > redirect_valid > sequential. Targets: EXC_VECTOR, epc, redirect_pc, pc+4 (modulo 2^WIDTH, wraps silently).
- Flush event (any of exc_req/eret_req/redirect_valid): pc<=target; FIFO cleared; drop<=drop+outstanding (responses in flight are discarded as they arrive); imem_req=0 that cycle; if_valid=0 next cycle.
- Issue: imem_req=1 iff no flush and (outstanding+fifo_count+drop) < DEPTH. imem_addr=pc. On imem_req&imem_gnt: pc<=pc+4, outstanding++.
- Response: on imem_rvalid: outstanding--; if drop>0 then drop-- and data discarded, else push {pc_of_request, imem_rdata} into FIFO. Request PCs held in an internal in-order address queue of DEPTH entries.
- Output: if_valid=FIFO non-empty; if_pc/if_instr=head (registered). Pop when if_valid & ~stall & no flush. Push and pop same cycle: count unchanged.
- Full: credit rule guarantees no push to full FIFO; an rvalid beyond outstanding is a protocol error, ignored.
- Empty with stall: nothing changes; if_valid stays 0.
- Flush and grant in same cycle: impossible (imem_req=0 on flush).
- Latency: reset release -> imem_req at cycle 1; zero-wait memory (rvalid one cycle after gnt) -> if_valid two cycles after grant; sustained throughput 1 instr/cycle with DEPTH>=2 and 1-cycle memory.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined: if pc[1:0]!=0 or target is misaligned, no memory request is issued; one FIFO entry {pc, 32'h0} with if_adel=1 is pushed (when credit allows); pc then holds until a flush. if_adel travels with its entry.
- Undefined: no check; imem_addr={pc[WIDTH-1:2],2'b00}; if_adel tied 0.

Test Plan:
- Reset release, memory gnt=1 and rvalid 1 cycle later -> imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_pc 0x3000 valid at cycle 3, then one per cycle.
- stall held 3 cycles with FIFO full (DEPTH=2) -> imem_req drops to 0; if_pc/if_instr stable; after release, no lost or duplicated instructions.
- redirect_valid with redirect_pc=0x3100 while 2 fetches outstanding -> both responses discarded; next imem_addr 0x3100; next if_pc 0x3100.
- exc_req and redirect_valid same cycle -> pc=0x4180 wins; later eret_req with epc=0x3044 -> fetch resumes at 0x3044.
- reset asserted mid-stream (asynchronous, between edges) -> if_valid=0 and imem_req=0 immediately; restart at 0x3000.
- With FETCH_ALIGN_CHECK_EN, redirect_pc=0x3102 -> no imem_req; if_valid=1, if_pc=0x3102, if_instr=0, if_adel=1; exc_req then fetches 0x4180 normally.
